// File: rtl/reqack_tph2rdyval_fifo_if.sv
// Handshake bundle for reqack_tph2rdyval_fifo: two-phase req/ack input side and ready/valid output side.
// The master modport is the environment (sender plus consumer); the slave modport is the converter.
interface reqack_tph2rdyval_fifo_if #(
    parameter int DWIDTH = 1
);
    logic              req;
    logic              ack;
    logic [DWIDTH-1:0] i_dat;
    logic              vld;
    logic              rdy;
    logic [DWIDTH-1:0] o_dat;

    modport master (output req, i_dat, rdy, input ack, vld, o_dat);
    modport slave  (input req, i_dat, rdy, output ack, vld, o_dat);
endinterface

// File: rtl/reqack_tph2rdyval_fifo.sv
// Two-phase req/ack to ready/valid converter with a DEPTH-entry buffer and optional req synchroniser.
// Define REQACK_TPH2RDYVAL_FIFO_LEVEL_EN to expose the registered occupancy on port level.
module reqack_tph2rdyval_fifo #(
    parameter int DWIDTH      = 1,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    reqack_tph2rdyval_fifo_if.slave      bus
`ifdef REQACK_TPH2RDYVAL_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   level
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Explicit wrap so non-power-of-2 depths stay inside the storage array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic req_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = bus.req;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= bus.req;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign req_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic              ack_q, ack_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic pending, full, not_empty, pop, push;

    always_comb begin
        pending   = req_s ^ ack_q;
        full      = (count_q == FULL_CNT);
        not_empty = (count_q != '0);
        pop       = not_empty && bus.rdy;
        // A full buffer still accepts when the head leaves in the same cycle.
        push      = pending && (!full || pop);

        ack_d   = ack_q ^ push;
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            ack_q   <= ack_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Storage is deliberately left unreset; o_dat is only meaningful while vld is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.i_dat;
    end

    assign bus.ack   = ack_q;
    assign bus.vld   = not_empty;
    assign bus.o_dat = mem_q[rptr_q];

`ifdef REQACK_TPH2RDYVAL_FIFO_LEVEL_EN
    assign level = count_q;
`endif

endmodule

// File: tb/tb_reqack_tph2rdyval_fifo.sv
// Bench for reqack_tph2rdyval_fifo: u0 (DEPTH=2, no sync) driven from a vector table,
// u1 (DEPTH=3, SYNC_STAGES=2) driven by a sender/consumer pair with random ready.
module tb_reqack_tph2rdyval_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reqack_tph2rdyval_fifo_if #(.DWIDTH(8)) if0 ();
    reqack_tph2rdyval_fifo_if #(.DWIDTH(8)) if1 ();

`ifdef REQACK_TPH2RDYVAL_FIFO_LEVEL_EN
    logic [1:0] level0;
    logic [1:0] level1;
`endif

    reqack_tph2rdyval_fifo #(.DWIDTH(8), .DEPTH(2), .SYNC_STAGES(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
`ifdef REQACK_TPH2RDYVAL_FIFO_LEVEL_EN
        ,
        .level (level0)
`endif
    );

    reqack_tph2rdyval_fifo #(.DWIDTH(8), .DEPTH(3), .SYNC_STAGES(2)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
`ifdef REQACK_TPH2RDYVAL_FIFO_LEVEL_EN
        ,
        .level (level1)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       req;
        logic [7:0] dat;
        logic       rdy;
        logic       ack;
        logic       vld;
        logic       chk_dat;
        logic [7:0] odat;
        logic [1:0] lvl;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    logic [7:0] exp_q [$];
    logic       c_vld, c_rdy;
    logic [7:0] c_dat;
    int         c_pops, c_cyc, s_lat;

    initial begin
        // Single transfer, then the DEPTH=2 fill / stall / drain sequence, then a 5-cycle rdy hold.
        vt[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd1};
        vt[1]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        vt[2]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1};
        vt[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 2'd2};
        vt[4]  = '{1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 2'd2};
        vt[5]  = '{1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 2'd2};
        vt[6]  = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 2'd2};
        vt[7]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 2'd2};
        vt[8]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 2'd1};
        vt[9]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        vt[10] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 2'd1};
        for (int i = 11; i < 16; i++)
            vt[i] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 2'd1};
        vt[16] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
        vt[17] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};

        if0.req = 1'b0; if0.i_dat = 8'h00; if0.rdy = 1'b0;
        if1.req = 1'b0; if1.i_dat = 8'h00; if1.rdy = 1'b0;

        #1;
        chk("rst_u0_ack", if0.ack, 0);
        chk("rst_u0_vld", if0.vld, 0);
        chk("rst_u1_ack", if1.ack, 0);
        chk("rst_u1_vld", if1.vld, 0);
`ifdef REQACK_TPH2RDYVAL_FIFO_LEVEL_EN
        chk("rst_u0_level", level0, 0);
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            if0.req = vt[i].req; if0.i_dat = vt[i].dat; if0.rdy = vt[i].rdy;
            tick();
            chk($sformatf("v%0d_ack", i), if0.ack, vt[i].ack);
            chk($sformatf("v%0d_vld", i), if0.vld, vt[i].vld);
            if (vt[i].chk_dat) chk($sformatf("v%0d_odat", i), if0.o_dat, vt[i].odat);
`ifdef REQACK_TPH2RDYVAL_FIFO_LEVEL_EN
            chk($sformatf("v%0d_level", i), level0, vt[i].lvl);
`endif
        end

        // Mid-operation reset with two entries buffered and ack high.
        if0.req = 1'b1; if0.i_dat = 8'h10; if0.rdy = 1'b0;
        tick();
        chk("mr_ack_a", if0.ack, 1);
        if0.rdy = 1'b1;
        tick();
        chk("mr_vld_a", if0.vld, 0);
        if0.rdy = 1'b0; if0.req = 1'b0; if0.i_dat = 8'h11;
        tick();
        if0.req = 1'b1; if0.i_dat = 8'h22;
        tick();
        chk("mr_ack_b", if0.ack, 1);
        chk("mr_vld_b", if0.vld, 1);
        chk("mr_odat_b", if0.o_dat, 8'h11);
        #2;
        rst_n = 1'b0; if0.req = 1'b0;
        #1;
        chk("mr_rst_ack", if0.ack, 0);
        chk("mr_rst_vld", if0.vld, 0);
`ifdef REQACK_TPH2RDYVAL_FIFO_LEVEL_EN
        chk("mr_rst_level", level0, 0);
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("mr_post_vld", if0.vld, 0);
        if0.req = 1'b1; if0.i_dat = 8'h33; if0.rdy = 1'b1;
        tick();
        chk("mr_post_ack", if0.ack, 1);
        chk("mr_post_vld1", if0.vld, 1);
        chk("mr_post_odat", if0.o_dat, 8'h33);
        tick();
        chk("mr_post_vld0", if0.vld, 0);

        // Synchronised instance: ordered delivery, pointer wrap, 3-edge ack latency while not full.
        c_pops = 0;
        c_cyc  = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    if1.i_dat = 8'($urandom_range(0, 255));
                    if1.req   = ~if1.req;
                    exp_q.push_back(if1.i_dat);
                    s_lat = 0;
                    do begin
                        tick();
                        s_lat++;
                    end while (if1.ack != if1.req && s_lat < 60);
                    chk($sformatf("u1_ack%0d", k), if1.ack, if1.req);
                    if (k < 3) chk($sformatf("u1_lat%0d", k), s_lat, 3);
                end
            end
            begin
                while (c_pops < 10 && c_cyc < 600) begin
                    if1.rdy = ($urandom_range(0, 2) != 0);
                    c_vld = if1.vld; c_dat = if1.o_dat; c_rdy = if1.rdy;
                    tick();
                    c_cyc++;
                    if (c_vld && c_rdy) begin
                        chk($sformatf("u1_q_nonempty%0d", c_pops), exp_q.size() != 0, 1);
                        if (exp_q.size() != 0)
                            chk($sformatf("u1_data%0d", c_pops), c_dat, exp_q.pop_front());
                        c_pops++;
                    end
                end
                chk("u1_pop_count", c_pops, 10);
            end
        join
        if1.rdy = 1'b1;
        tick();
        chk("u1_drained_vld", if1.vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
